// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in serial-out serializer.
// Holds the FSM state encoding and the bit-counter width rule.
package piso_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Counter must stay at least one bit wide so WIDTH=1 still has a port.
  function automatic int cnt_width(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/piso_ser_shift_core.sv
// Parallel-load shift register with a single output-end tap.
// load has priority over shift; with neither asserted the contents hold.
module shift_core #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             tap
);

  logic [WIDTH-1:0] sreg_reg;
  logic [WIDTH-1:0] sreg_next;
  logic [WIDTH-1:0] shifted;

  // Move one place toward the output end, zero-filling the vacated bit.
  generate
    if (WIDTH == 1) begin : gen_w1
      assign shifted = '0;
      assign tap     = sreg_reg[0];
    end else if (MSB_FIRST) begin : gen_msb
      assign shifted = {sreg_reg[WIDTH-2:0], 1'b0};
      assign tap     = sreg_reg[WIDTH-1];
    end else begin : gen_lsb
      assign shifted = {1'b0, sreg_reg[WIDTH-1:1]};
      assign tap     = sreg_reg[0];
    end
  endgenerate

  always_comb begin
    sreg_next = sreg_reg;
    if (load) begin
      sreg_next = din;
    end else if (shift) begin
      sreg_next = shifted;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_reg <= '0;
    end else begin
      sreg_reg <= sreg_next;
    end
  end

endmodule

// File: rtl/piso_ser.sv
// Parallel-in serial-out serializer with valid/ready load and stallable output.
// Back-to-back words stream with no bubble when the last bit is consumed.
module piso_ser
  import piso_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0,
  localparam int CW        = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] din,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             last,
  output logic             busy,
  output logic [CW-1:0]    bit_cnt
);

  state_t        state_reg;
  state_t        state_next;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  logic last_bit;
  logic accept;
  logic core_shift;
  logic tap;

  assign last_bit   = (state_reg == ST_SHIFT) && (cnt_reg == CW'(WIDTH - 1));
  // Only combinational path from shift_en to an output.
  assign load_ready = (state_reg == ST_IDLE) || (last_bit && shift_en);
  assign accept     = load_valid && load_ready;
  assign core_shift = (state_reg == ST_SHIFT) && shift_en && !last_bit;

  shift_core #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .shift(core_shift),
    .din  (din),
    .tap  (tap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_SHIFT;
          cnt_next   = '0;
        end
      end
      ST_SHIFT: begin
        if (shift_en) begin
          if (last_bit) begin
            state_next = accept ? ST_SHIFT : ST_IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    sout_valid = (state_reg == ST_SHIFT);
    busy       = (state_reg == ST_SHIFT);
    sout       = (state_reg == ST_SHIFT) ? tap : IDLE_LEVEL;
    last       = last_bit;
    bit_cnt    = cnt_reg;
  end

endmodule
